// File: rtl/term_byte_decoder.sv
// Byte-stream front end for the vgachar display: turns ASCII/ANSI bytes into char/row/column strobes.
// Optional SGR colour support is enabled by defining TERM_SGR_COLOR_EN.
module term_byte_decoder #(
    parameter int ROWS = 30,
    parameter int COLS = 80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic [4:0]  cur_row,
    input  logic [6:0]  cur_col,
    output logic        data_strobe,
    output logic        row_strobe,
    output logic        col_strobe,
    output logic [7:0]  dout,
    output logic [11:0] fg_color,
    output logic [11:0] bg_color
);
    typedef enum logic [2:0] {IDLE, ESC, CSI, EMIT_ROW, EMIT_COL} state_t;

    localparam logic [7:0] ROWS8    = 8'(ROWS);
    localparam logic [7:0] COLS8    = 8'(COLS);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    state_t      state_reg, state_next;
    logic [7:0]  p0_reg, p0_next, p1_reg, p1_next;
    logic [1:0]  idx_reg, idx_next;  // 2 = beyond the second param, digits discarded
    logic        data_strobe_reg, data_strobe_next;
    logic        row_strobe_reg, row_strobe_next;
    logic        col_strobe_reg, col_strobe_next;
    logic [7:0]  dout_reg, dout_next;
    logic        accept;

    function automatic logic [7:0] acc_digit(input logic [7:0] p, input logic [3:0] d);
        logic [11:0] s;
        s = {4'd0, p} * 12'd10 + {8'd0, d};
        return (s > 12'd255) ? 8'hFF : s[7:0];
    endfunction

    // Missing/zero param means 1, then clamp to the display size and convert to 0-based.
    function automatic logic [7:0] to_pos(input logic [7:0] p, input logic [7:0] lim);
        logic [7:0] v;
        v = (p == 8'd0) ? 8'd1 : p;
        if (v > lim) v = lim;
        return v - 8'd1;
    endfunction

    assign in_ready    = (state_reg == IDLE) || (state_reg == ESC) || (state_reg == CSI);
    assign accept      = in_valid && in_ready;
    assign data_strobe = data_strobe_reg;
    assign row_strobe  = row_strobe_reg;
    assign col_strobe  = col_strobe_reg;
    assign dout        = dout_reg;

    always_comb begin
        state_next       = state_reg;
        p0_next          = p0_reg;
        p1_next          = p1_reg;
        idx_next         = idx_reg;
        data_strobe_next = 1'b0;
        row_strobe_next  = 1'b0;
        col_strobe_next  = 1'b0;
        dout_next        = dout_reg;
        case (state_reg)
            IDLE: if (accept) begin
                if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                    data_strobe_next = 1'b1;
                    dout_next        = in_data;
                end else if (in_data == 8'h0D) begin
                    col_strobe_next = 1'b1;
                    dout_next       = 8'd0;
                end else if (in_data == 8'h0A) begin
                    row_strobe_next = 1'b1;
                    dout_next       = (cur_row == LAST_ROW) ? 8'd0 : {3'd0, cur_row + 5'd1};
                end else if (in_data == 8'h08) begin
                    if (cur_col != 7'd0) begin
                        col_strobe_next = 1'b1;
                        dout_next       = {1'b0, cur_col - 7'd1};
                    end
                end else if (in_data == 8'h1B) begin
                    state_next = ESC;
                end
            end
            ESC: if (accept) begin
                if (in_data == 8'h5B) begin
                    state_next = CSI;
                    p0_next    = 8'd0;
                    p1_next    = 8'd0;
                    idx_next   = 2'd0;
                end else begin
                    state_next = IDLE;
                end
            end
            CSI: if (accept) begin
                if (in_data >= 8'h30 && in_data <= 8'h39) begin
                    if (idx_reg == 2'd0) p0_next = acc_digit(p0_reg, in_data[3:0]);
                    if (idx_reg == 2'd1) p1_next = acc_digit(p1_reg, in_data[3:0]);
                end else if (in_data == 8'h3B) begin
                    if (idx_reg != 2'd2) idx_next = idx_reg + 2'd1;
                end else if (in_data == 8'h48 || in_data == 8'h66) begin
                    state_next      = EMIT_ROW;
                    row_strobe_next = 1'b1;
                    dout_next       = to_pos(p0_reg, ROWS8);
                end else begin
                    state_next = IDLE;  // 'm' and any abort byte
                end
            end
            EMIT_ROW: begin
                state_next      = EMIT_COL;
                col_strobe_next = 1'b1;
                dout_next       = to_pos(p1_reg, COLS8);
            end
            EMIT_COL: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            p0_reg          <= 8'd0;
            p1_reg          <= 8'd0;
            idx_reg         <= 2'd0;
            data_strobe_reg <= 1'b0;
            row_strobe_reg  <= 1'b0;
            col_strobe_reg  <= 1'b0;
            dout_reg        <= 8'd0;
        end else begin
            state_reg       <= state_next;
            p0_reg          <= p0_next;
            p1_reg          <= p1_next;
            idx_reg         <= idx_next;
            data_strobe_reg <= data_strobe_next;
            row_strobe_reg  <= row_strobe_next;
            col_strobe_reg  <= col_strobe_next;
            dout_reg        <= dout_next;
        end
    end

`ifdef TERM_SGR_COLOR_EN
    logic [11:0] fg_reg, bg_reg;
    logic [23:0] colors_next;

    function automatic logic [11:0] palette(input logic [2:0] i);
        case (i)
            3'd0: return 12'h000;
            3'd1: return 12'hF00;
            3'd2: return 12'h0F0;
            3'd3: return 12'hFF0;
            3'd4: return 12'h00F;
            3'd5: return 12'hF0F;
            3'd6: return 12'h0FF;
            default: return 12'hFFF;
        endcase
    endfunction

    // {fg, bg} after applying one SGR code; unknown codes leave colours alone.
    function automatic logic [23:0] sgr(input logic [7:0] code, input logic [23:0] cur);
        logic [7:0] off;
        sgr = cur;
        if (code == 8'd0) begin
            sgr = {12'hFFF, 12'h000};
        end else if (code >= 8'd30 && code <= 8'd37) begin
            off = code - 8'd30;
            sgr = {palette(off[2:0]), cur[11:0]};
        end else if (code >= 8'd40 && code <= 8'd47) begin
            off = code - 8'd40;
            sgr = {cur[23:12], palette(off[2:0])};
        end
    endfunction

    always_comb begin
        colors_next = {fg_reg, bg_reg};
        if (state_reg == CSI && accept && in_data == 8'h6D) begin
            colors_next = sgr(p0_reg, colors_next);
            if (idx_reg != 2'd0) colors_next = sgr(p1_reg, colors_next);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fg_reg <= 12'hFFF;
            bg_reg <= 12'h000;
        end else begin
            fg_reg <= colors_next[23:12];
            bg_reg <= colors_next[11:0];
        end
    end

    assign fg_color = fg_reg;
    assign bg_color = bg_reg;
`else
    assign fg_color = 12'hFFF;
    assign bg_color = 12'h000;
`endif
endmodule
